// File: rtl/csr_ex_stage.sv
// Execute-stage Zicsr unit: one-entry EX register, computes the new CSR value and
// drives the CSR write port and the rd write-back in the cycle the entry retires.
module csr_ex_stage #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic            id_valid_i,
  output logic            id_ready_o,
  input  logic [2:0]      id_funct3_i,
  input  logic [11:0]     id_csr_addr_i,
  input  logic [4:0]      id_rs1_idx_i,
  input  logic [XLEN-1:0] id_rs1_data_i,
  input  logic [4:0]      id_rd_idx_i,
  input  logic [XLEN-1:0] id_csr_rdata_i,
  input  logic            wb_ready_i,
  output logic [11:0]     ex_waddr_o,
  output logic [XLEN-1:0] ex_wdata_o,
  output logic            ex_we_o,
  output logic            rd_we_o,
  output logic [4:0]      rd_idx_o,
  output logic [XLEN-1:0] rd_wdata_o,
  output logic            illegal_o
);

  logic            ex_valid_q, ex_valid_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [11:0]     addr_q, addr_d;
  logic [XLEN-1:0] operand_q, operand_d;
  logic            rs1_zero_q, rs1_zero_d;
  logic [4:0]      rd_q, rd_d;
  logic [XLEN-1:0] old_q, old_d;

  logic            capture, leave, write_req, illegal;
  logic [XLEN-1:0] new_val;

  always_comb begin
    id_ready_o = ~ex_valid_q | (wb_ready_i & ~flush_i);
    leave      = ex_valid_q & wb_ready_i & ~flush_i;
    capture    = id_valid_i & id_ready_o & ~flush_i;

    ex_valid_d = ex_valid_q;
    funct3_d   = funct3_q;
    addr_d     = addr_q;
    operand_d  = operand_q;
    rs1_zero_d = rs1_zero_q;
    rd_d       = rd_q;
    old_d      = old_q;

    if (capture) begin
      ex_valid_d = 1'b1;
      funct3_d   = id_funct3_i;
      addr_d     = id_csr_addr_i;
      operand_d  = id_funct3_i[2] ? {{(XLEN-5){1'b0}}, id_rs1_idx_i} : id_rs1_data_i;
      rs1_zero_d = (id_rs1_idx_i == 5'd0);
      rd_d       = id_rd_idx_i;
      old_d      = id_csr_rdata_i;
    end else if (leave || flush_i) begin
      ex_valid_d = 1'b0;
    end
  end

  // Set/clear with x0 or zimm 0 is a pure read and must not touch the CSR.
  always_comb begin
    write_req = 1'b0;
    new_val   = operand_q;
    case (funct3_q[1:0])
      2'b01: write_req = 1'b1;
      2'b10: begin
        write_req = ~rs1_zero_q;
        new_val   = old_q | operand_q;
      end
      2'b11: begin
        write_req = ~rs1_zero_q;
        new_val   = old_q & ~operand_q;
      end
      default: write_req = 1'b0;
    endcase
    illegal = (funct3_q[1:0] == 2'b00) | (write_req & (addr_q[11:10] == 2'b11));
  end

  always_comb begin
    ex_we_o    = leave & write_req & ~illegal;
    rd_we_o    = leave & ~illegal & (rd_q != 5'd0);
    illegal_o  = leave & illegal;
    ex_waddr_o = ex_valid_q ? addr_q  : 12'd0;
    ex_wdata_o = ex_valid_q ? new_val : '0;
    rd_idx_o   = ex_valid_q ? rd_q    : 5'd0;
    rd_wdata_o = ex_valid_q ? old_q   : '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ex_valid_q <= 1'b0;
      funct3_q   <= 3'd0;
      addr_q     <= 12'd0;
      operand_q  <= '0;
      rs1_zero_q <= 1'b0;
      rd_q       <= 5'd0;
      old_q      <= '0;
    end else begin
      ex_valid_q <= ex_valid_d;
      funct3_q   <= funct3_d;
      addr_q     <= addr_d;
      operand_q  <= operand_d;
      rs1_zero_q <= rs1_zero_d;
      rd_q       <= rd_d;
      old_q      <= old_d;
    end
  end

endmodule
